// File: rtl/aes_round_controller.sv
// aes_round_controller: iterative AES-128/192/256 encryptor, one round per clock behind valid/ready handshakes.
module aes_round_controller #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  input  logic [32*NK-1:0] in_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic            busy,
  output logic [3:0]      round
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  fsm_t fsm, fsm_d;
  logic [32*NK-1:0] key_q, key_d;
  logic [127:0] state_q, state_d, rk;
  logic [3:0] round_d;
  logic valid_q, valid_d;
  logic [128*(NR+1)-1:0] ek;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, p;
    x = a;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse (x^254) plus the affine map, so no table to mistype
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gmul(b, b);
    x3   = gmul(x2, b);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [128*(NR+1)-1:0] key_exp(input logic [32*NK-1:0] k);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    logic [7:0] rc;
    logic [128*(NR+1)-1:0] e;
    rc = 8'h01;
    e = '0;
    for (int i = 0; i < 4*(NR+1); i++) begin
      if (i < NK) w[i] = k[32*NK-1-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (NK > 6 && i % NK == 4) t = sub_word(t);
        w[i] = w[i-NK] ^ t;
      end
      e[128*(NR+1)-1-32*i -: 32] = w[i];
    end
    return e;
  endfunction

  always_comb begin
    ek = key_exp(key_q);
    rk = ek[128*(NR+1)-1-128*int'(round) -: 128];
  end

  always_comb begin
    fsm_d = fsm;
    key_d = key_q;
    state_d = state_q;
    round_d = round;
    // ciphertext is presented one cycle after DONE is entered, giving a registered out_valid
    valid_d = fsm == DONE && !(valid_q && out_ready);
    case (fsm)
      IDLE: if (in_valid) begin
        key_d = in_key;
        state_d = in_data ^ in_key[32*NK-1 -: 128];
        round_d = 4'd1;
        fsm_d = ROUND;
      end
      ROUND: begin
        state_d = mix(sub_shift(state_q)) ^ rk;
        round_d = round + 4'd1;
        fsm_d = round == 4'(NR-1) ? FINAL : ROUND;
      end
      FINAL: begin
        state_d = sub_shift(state_q) ^ rk;
        round_d = 4'(NR);
        fsm_d = DONE;
      end
      DONE: if (valid_q && out_ready) begin
        fsm_d = IDLE;
        round_d = '0;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      key_q <= '0;
      state_q <= '0;
      round <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm <= fsm_d;
      key_q <= key_d;
      state_q <= state_d;
      round <= round_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready = fsm == IDLE && !rst;
  assign out_valid = valid_q;
  assign out_data = state_q;
  assign busy = fsm != IDLE;
endmodule

// File: tb/tb_aes_round_controller.sv
// tb_aes_round_controller: directed FIPS-197 vectors with a queue scoreboard, backpressure, busy-input and reset-abort cases.
module tb_aes_round_controller;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic in_valid = 0, out_ready = 1, in_ready, out_valid, busy;
  logic [127:0] in_data = '0, in_key = '0, out_data;
  logic [3:0] round;

  logic v6 = 0, r6, ov6, b6;
  logic [191:0] k6 = '0;
  logic [127:0] od6;
  logic [3:0] rd6;
  logic v8 = 0, r8, ov8, b8;
  logic [255:0] k8 = '0;
  logic [127:0] od8;
  logic [3:0] rd8;

  aes_round_controller #(.NR(10), .NK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .round(round));
  aes_round_controller #(.NR(12), .NK(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6), .in_data(P1), .in_key(k6),
    .out_valid(ov6), .out_ready(1'b1), .out_data(od6), .busy(b6), .round(rd6));
  aes_round_controller #(.NR(14), .NK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(P1), .in_key(k8),
    .out_valid(ov8), .out_ready(1'b1), .out_data(od8), .busy(b8), .round(rd8));

  int n_checks = 0, n_fail = 0, cyc = 0, last_acc = 0;
  logic [127:0] exp_q[$];
  int acc_q[$];
  logic prev_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard side: latency on each out_valid rise, data on each out handshake
  always @(negedge clk) begin
    if (out_valid && !prev_v && acc_q.size() != 0) chk("latency", 128'(cyc - acc_q.pop_front()), 128'(11));
    prev_v = out_valid;
    if (out_valid && out_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: observed %h expected no output", out_data);
      end
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] ex);
    in_valid = 1;
    in_key = k;
    in_data = pt;
    for (int i = 0; i < 60 && !in_ready; i++) step();
    chk("accept_ready", 128'(in_ready), 128'(1));
    exp_q.push_back(ex);
    step();
    acc_q.push_back(cyc);
    last_acc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    chk("drain", 128'(exp_q.size()), 128'(0));
    step();
  endtask

  initial begin
    int a1, t6, t8;
    step(2);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    rst = 0;
    #1 chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    send(K1, P1, C1);
    a1 = last_acc;
    send(K2, P2, C2);
    chk("accept_spacing", 128'(last_acc - a1), 128'(13));
    wait_done();

    out_ready = 0;
    send(K1, P1, C1);
    for (int i = 0; i < 30 && !out_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_data", out_data, C1);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      step();
    end
    out_ready = 1;
    step();
    chk("release_idle", 128'(in_ready), 128'(1));
    chk("release_valid", 128'(out_valid), 128'(0));
    chk("release_drained", 128'(exp_q.size()), 128'(0));

    send(K1, P1, C1);
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_key = {$urandom, $urandom, $urandom, $urandom};
      in_data = {$urandom, $urandom, $urandom, $urandom};
      chk("busy_in_ready", 128'(in_ready), 128'(0));
      chk("busy_flag", 128'(busy), 128'(1));
      step();
    end
    in_valid = 0;
    wait_done();
    step(3);
    chk("no_extra_accept", 128'(busy), 128'(0));

    send(K1, P1, C1);
    for (int i = 0; i < 20 && round != 4'd5; i++) step();
    chk("reach_round5", 128'(round), 128'(5));
    rst = 1;
    step();
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_round", 128'(round), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    exp_q.delete();
    acc_q.delete();
    rst = 0;
    #1 chk("abort_in_ready", 128'(in_ready), 128'(1));
    send(K1, P1, C1);
    wait_done();

    k6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    k8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    chk("nk6_ready", 128'(r6), 128'(1));
    chk("nk8_ready", 128'(r8), 128'(1));
    v6 = 1;
    v8 = 1;
    step();
    a1 = cyc;
    v6 = 0;
    v8 = 0;
    t6 = -1;
    t8 = -1;
    for (int i = 0; i < 40 && (t6 < 0 || t8 < 0); i++) begin
      step();
      if (ov6 && t6 < 0) begin
        t6 = cyc - a1;
        chk("nk6_data", od6, C6);
      end
      if (ov8 && t8 < 0) begin
        t8 = cyc - a1;
        chk("nk8_data", od8, C8);
      end
    end
    chk("nk6_latency", 128'(t6), 128'(13));
    chk("nk8_latency", 128'(t8), 128'(15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
